vect_input_arbiter: RTL

//  Shares one vectorization unit (VU) between NUM_REQ router input streams.

---
 rtl/vect_input_arbiter_pkg.sv | 16 +
 rtl/vect_input_arbiter_rr_arbiter.sv | 34 +++
 rtl/vect_input_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vect_input_arbiter_pkg.sv
// Shared types and sizing for the vectorization-unit input arbiter.
// Flits carry a header flag in the MSB above a DATA_WIDTH payload.
package vect_input_arbiter_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int PACKET_LENGTH = DATA_WIDTH + 1;
  localparam int FEATURES      = 4;
  localparam int NUM_REQ       = 4;
  localparam int REQ_ID_W      = $clog2(NUM_REQ);
  localparam int HDR_BIT       = PACKET_LENGTH - 1;

  typedef enum logic [1:0] {IDLE, BURST, WAIT_VEC} vect_arb_state_t;

  typedef logic [PACKET_LENGTH-1:0] packet_t;

endpackage

// File: rtl/vect_input_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Requests below ptr are masked in the low half so the wrapped copy only wins when nothing is above.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int ID_W = $clog2(N);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    dbl     = {req, masked};
    gnt_vld = 1'b0;
    gnt_id  = '0;
    // Descending scan so the lowest set bit of the doubled vector wins.
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(i % N);
      end
    end
  end

endmodule

// File: rtl/vect_input_arbiter.sv
// Grants one router input stream at a time to the shared vectorization unit,
// holding the grant for a whole vector and reporting the node tag when it completes.
module vect_input_arbiter
  import vect_input_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = vect_input_arbiter_pkg::NUM_REQ,
  parameter int FEATURES = vect_input_arbiter_pkg::FEATURES,
  parameter int CNT_W    = $clog2(FEATURES)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  packet_t [NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]    req_reading,
  output logic                  vu_vld,
  output packet_t               vu_din,
  input  logic                  vu_reading,
  input  logic                  vu_vec_vld,
  output logic [DATA_WIDTH-1:0] vec_tag,
  output logic                  vec_tag_vld,
  output logic                  err
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FEATURES - 1);

  vect_arb_state_t    state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] cand;
  logic               arb_vld;
  logic [ID_W-1:0]    arb_id;
  packet_t            g_din;
  logic               g_vld;
  logic               g_hdr;
  logic               accept;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = req_vld[i] & req_din[i][HDR_BIT];
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (cand),
    .ptr     (rr_ptr),
    .gnt_vld (arb_vld),
    .gnt_id  (arb_id)
  );

  assign g_vld  = req_vld[grant];
  assign g_din  = req_din[grant];
  assign g_hdr  = g_vld & g_din[HDR_BIT];
  assign accept = (state == BURST) & g_vld & ~g_hdr & vu_reading;

  // Outputs are forced low while arst is held, even with headers waiting upstream.
  always_comb begin
    req_reading = '0;
    vu_vld      = 1'b0;
    vu_din      = '0;
    vec_tag_vld = 1'b0;
    if (!arst) begin
      case (state)
        IDLE: begin
          if (arb_vld) req_reading[arb_id] = 1'b1;
        end
        BURST: begin
          vu_din = g_din;
          if (!g_hdr) begin
            vu_vld             = g_vld;
            req_reading[grant] = vu_reading;
          end
        end
        WAIT_VEC: begin
          vec_tag_vld = vu_vec_vld;
        end
        default: ;
      endcase
    end
  end

  // A stray header inside a burst is never consumed, so the block stays stalled until arst.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      cnt     <= '0;
      vec_tag <= '0;
      err     <= 1'b0;
    end else begin
      if (vu_vec_vld && state != WAIT_VEC) err <= 1'b1;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            vec_tag <= req_din[arb_id][DATA_WIDTH-1:0];
            grant   <= arb_id;
            cnt     <= '0;
            state   <= BURST;
          end
        end
        BURST: begin
          if (g_hdr) begin
            err <= 1'b1;
          end else if (accept) begin
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= WAIT_VEC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_VEC: begin
          if (vu_vec_vld) begin
            rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
